// File: rtl/rom_seq_pkg.sv
// Shared encodings for the synchronous instruction ROM:
// FSM states, MIPS opcode/register fields and word builders.
package rom_seq_pkg;

  localparam logic [0:0] RS_INIT = 1'b0;
  localparam logic [0:0] RS_RUN  = 1'b1;

  localparam logic [31:0] NOP = 32'h0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [4:0] R0 = 5'd0;
  localparam logic [4:0] R1 = 5'd1;
  localparam logic [4:0] R2 = 5'd2;
  localparam logic [4:0] R3 = 5'd3;
  localparam logic [4:0] R4 = 5'd4;
  localparam logic [4:0] R5 = 5'd5;
  localparam logic [4:0] R6 = 5'd6;
  localparam logic [4:0] R7 = 5'd7;

  function automatic logic [31:0] enc_i(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [15:0] imm
  );
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [5:0]  op,
    input logic [25:0] tgt
  );
    return {op, tgt};
  endfunction

endpackage

// File: rtl/rom_seq_boot_table.sv
// Boot program: combinational map from word index to boot word.
// Unlisted indices hold NOP.
module rom_boot_table
  import rom_seq_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 9
) (
  input  logic [IDX_W-1:0]  idx,
  output logic [DATA_W-1:0] word
);

  logic [31:0] boot;

  always_comb begin
    boot = NOP;
    case (32'(idx))
      32'h000: boot = enc_i(OP_ADDI, R0, R1, 16'd8);
      32'h02c: boot = enc_i(OP_BEQ, R6, R1, 16'd7);
      32'h044: boot = enc_j(OP_J, 26'h08);
      default: boot = NOP;
    endcase
  end

  assign word = DATA_W'(boot);

endmodule

// File: rtl/rom_seq.sv
// Synchronous instruction ROM: boot loader sequencer, registered
// reads with fault reporting, optional patch write port.
module rom_seq
  import rom_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 512,
  parameter int ADDR_W   = 11,
  parameter int WRITABLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nce,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              ready,
  output logic              valid,
  output logic              fault,
  output logic [DATA_W-1:0] d_out
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [0:0]        state;
  logic [IW-1:0]     init_cnt;
  logic [DATA_W-1:0] boot_word;
  logic [DATA_W-1:0] rdata;

  logic in_run;
  logic req;
  logic rd_ok;
  logic wr_go;

  // Aligned and the word index lies inside the array.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-3:0] w;
    w = a[ADDR_W-1:2];
    return (a[1:0] == 2'b00) && ((w >> IW) == '0);
  endfunction

  rom_boot_table #(
    .DATA_W(DATA_W),
    .IDX_W (IW)
  ) u_boot (
    .idx (init_cnt),
    .word(boot_word)
  );

  assign in_run = (state == RS_RUN);
  assign req    = in_run & ~nce & re;
  assign rd_ok  = addr_ok(addr);
  assign wr_go  = (WRITABLE != 0) & in_run
                & wr_en & addr_ok(wr_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RS_INIT;
      init_cnt <= '0;
      ready    <= 1'b0;
    end else if (state == RS_INIT) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == IW'(DEPTH - 1)) begin
        state <= RS_RUN;
        ready <= 1'b1;
      end
    end
  end

  // Single write port shared by the boot loader and the patch port.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == RS_INIT)
        mem[init_cnt] <= boot_word;
      else if (wr_go)
        mem[wr_addr[IW+1:2]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      fault <= 1'b0;
      rdata <= '0;
    end else begin
      valid <= req;
      fault <= req & ~rd_ok;
      if (req)
        rdata <= rd_ok ? mem[addr[IW+1:2]] : '0;
    end
  end

  assign d_out = valid ? rdata : {DATA_W{1'bz}};

endmodule
